// File: rtl/alu_sequencer.sv
// alu_sequencer: IDLE/EXEC/WB controller for the accumulator/carry registers and the 4-bit ALU.
// Defining ALU_SEQ_OPCOUNT_EN adds a saturating op_count output.
module alu_sequencer #(
    parameter logic [3:0] ACC_RESET = 4'h0
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [3:0] op_code,
    input  logic [3:0] op_data,
    input  logic [3:0] reg_in,
    output logic [2:0] alu_op,
    output logic [2:0] alu_in0_sel,
    output logic [1:0] alu_in1_sel,
    output logic [1:0] alu_cin_sel,
    output logic [3:0] alu_regval,
    output logic [3:0] alu_acc,
    output logic [3:0] alu_data,
    output logic       alu_carry,
    input  logic [4:0] alu_result,
    output logic       reg_we,
    output logic [3:0] reg_wdata,
    output logic [3:0] acc,
    output logic       carry,
`ifdef ALU_SEQ_OPCOUNT_EN
    output logic       done,
    output logic [7:0] op_count
`else
    output logic       done
`endif
);
    localparam logic [2:0] OP_PASS = 3'd0, OP_ADD = 3'd1, OP_ROL = 3'd2, OP_ROR = 3'd3, OP_DEC_A = 3'd4;
    localparam logic [2:0] IN0_ACC = 3'd0, IN0_REG = 3'd1, IN0_REG_INV = 3'd2, IN0_ACC_INV = 3'd3, IN0_DATA = 3'd4;
    localparam logic [1:0] IN1_ACC = 2'd0, IN1_REG = 2'd1, IN1_ONE = 2'd2;
    localparam logic [1:0] CIN_CARRY = 2'd0, CIN_ZERO = 2'd1, CIN_ONE = 2'd2, CIN_CARRY_INV = 2'd3;
    localparam logic [3:0] C_XCH = 4'd4, C_LDM = 4'd6;

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t     state;
    logic [3:0] op_q, data_q, reg_q;
    logic [4:0] result_q;
    logic       acc_we_q, carry_we_q, reg_wr_q;
    logic [2:0] d_op, d_in0;
    logic [1:0] d_in1, d_cin;
    logic       d_acc_we, d_carry_we, d_reg_we;

    assign alu_regval = reg_q;
    assign alu_acc    = acc;
    assign alu_carry  = carry;
    assign alu_data   = (op_q == C_LDM) ? data_q : 4'h0;

    always_comb begin
        d_op       = OP_PASS;
        d_in0      = IN0_ACC;
        d_in1      = IN1_ACC;
        d_cin      = CIN_CARRY;
        d_acc_we   = 1'b0;
        d_carry_we = 1'b0;
        d_reg_we   = 1'b0;
        case (op_code)
            4'd1:  begin d_op = OP_ADD; d_in1 = IN1_REG; d_acc_we = 1'b1; d_carry_we = 1'b1; end
            4'd2:  begin d_op = OP_ADD; d_in0 = IN0_REG_INV; d_cin = CIN_CARRY_INV; d_acc_we = 1'b1; d_carry_we = 1'b1; end
            4'd3:  begin d_in0 = IN0_REG; d_acc_we = 1'b1; end
            4'd4:  begin d_in0 = IN0_REG; d_acc_we = 1'b1; d_reg_we = 1'b1; end
            4'd5:  begin d_op = OP_ADD; d_in0 = IN0_REG; d_in1 = IN1_ONE; d_cin = CIN_ZERO; d_reg_we = 1'b1; end
            4'd6:  begin d_in0 = IN0_DATA; d_acc_we = 1'b1; end
            4'd7:  begin d_in0 = IN0_DATA; d_cin = CIN_ZERO; d_acc_we = 1'b1; d_carry_we = 1'b1; end
            4'd8:  begin d_cin = CIN_ZERO; d_carry_we = 1'b1; end
            4'd9:  begin d_cin = CIN_CARRY_INV; d_carry_we = 1'b1; end
            4'd10: begin d_cin = CIN_ONE; d_carry_we = 1'b1; end
            4'd11: begin d_in0 = IN0_ACC_INV; d_acc_we = 1'b1; end
            4'd12: begin d_op = OP_ROL; d_acc_we = 1'b1; d_carry_we = 1'b1; end
            4'd13: begin d_op = OP_ROR; d_acc_we = 1'b1; d_carry_we = 1'b1; end
            4'd14: begin d_op = OP_DEC_A; d_acc_we = 1'b1; d_carry_we = 1'b1; end
            4'd15: begin d_op = OP_ADD; d_in1 = IN1_ONE; d_cin = CIN_ZERO; d_acc_we = 1'b1; d_carry_we = 1'b1; end
            default: ;
        endcase
    end

    // ALU controls are registered at accept so EXEC sees a stable decode, independent of op_code.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            op_ready    <= 1'b1;
            op_q        <= 4'h0;
            data_q      <= 4'h0;
            reg_q       <= 4'h0;
            result_q    <= 5'h0;
            acc_we_q    <= 1'b0;
            carry_we_q  <= 1'b0;
            reg_wr_q    <= 1'b0;
            alu_op      <= OP_PASS;
            alu_in0_sel <= IN0_ACC;
            alu_in1_sel <= IN1_ACC;
            alu_cin_sel <= CIN_CARRY;
            acc         <= ACC_RESET;
            carry       <= 1'b0;
            done        <= 1'b0;
            reg_we      <= 1'b0;
            reg_wdata   <= 4'h0;
        end else begin
            done   <= 1'b0;
            reg_we <= 1'b0;
            case (state)
                IDLE: if (op_valid) begin
                    op_q        <= op_code;
                    data_q      <= op_data;
                    reg_q       <= reg_in;
                    acc_we_q    <= d_acc_we;
                    carry_we_q  <= d_carry_we;
                    reg_wr_q    <= d_reg_we;
                    alu_op      <= d_op;
                    alu_in0_sel <= d_in0;
                    alu_in1_sel <= d_in1;
                    alu_cin_sel <= d_cin;
                    op_ready    <= 1'b0;
                    state       <= EXEC;
                end
                EXEC: begin
                    result_q <= alu_result;
                    state    <= WB;
                end
                WB: begin
                    if (acc_we_q) acc <= result_q[3:0];
                    if (carry_we_q) carry <= result_q[4];
                    reg_we      <= reg_wr_q;
                    reg_wdata   <= (op_q == C_XCH) ? acc : result_q[3:0];
                    done        <= 1'b1;
                    alu_op      <= OP_PASS;
                    alu_in0_sel <= IN0_ACC;
                    alu_in1_sel <= IN1_ACC;
                    alu_cin_sel <= CIN_CARRY;
                    op_ready    <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    op_ready <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_SEQ_OPCOUNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) op_count <= 8'h00;
        else if (state == WB && op_count != 8'hFF) op_count <= op_count + 8'h01;
    end
`endif
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: randomized scoreboard bench; the ALU is modelled here and ops are predicted from their arithmetic meaning.
module tb_alu_sequencer;
    localparam logic [3:0] ACC_R = 4'h0;

    typedef struct {
        int acc;
        int c;
        int we;
        int wd;
        int cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       op_valid = 1'b0;
    logic       op_ready;
    logic [3:0] op_code = 4'h0, op_data = 4'h0, reg_in = 4'h0;
    logic [2:0] alu_op, alu_in0_sel;
    logic [1:0] alu_in1_sel, alu_cin_sel;
    logic [3:0] alu_regval, alu_acc, alu_data;
    logic       alu_carry;
    logic [4:0] alu_result;
    logic       reg_we, carry, done;
    logic [3:0] reg_wdata, acc;
`ifdef ALU_SEQ_OPCOUNT_EN
    logic [7:0] op_count;
`endif

    int   tests = 0, fails = 0, cyc = 0;
    int   m_acc = 0, m_c = 0;
    exp_t q[$];

    alu_sequencer #(.ACC_RESET(ACC_R)) dut (
        .clock(clk), .reset_n(reset_n), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_data(op_data), .reg_in(reg_in),
        .alu_op(alu_op), .alu_in0_sel(alu_in0_sel), .alu_in1_sel(alu_in1_sel), .alu_cin_sel(alu_cin_sel),
        .alu_regval(alu_regval), .alu_acc(alu_acc), .alu_data(alu_data), .alu_carry(alu_carry),
        .alu_result(alu_result), .reg_we(reg_we), .reg_wdata(reg_wdata), .acc(acc), .carry(carry),
`ifdef ALU_SEQ_OPCOUNT_EN
        .done(done), .op_count(op_count)
`else
        .done(done)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural 4-bit ALU answering the sequencer's select lines.
    function automatic logic [4:0] alu_fn(input logic [2:0] op, input logic [2:0] s0, input logic [1:0] s1,
                                          input logic [1:0] sc, input logic [3:0] rv, av, dv, input logic cv);
        int a, b, c, r;
        a = (s0 == 0) ? int'(av) : (s0 == 1) ? int'(rv) : (s0 == 2) ? 15 - int'(rv) :
            (s0 == 3) ? 15 - int'(av) : (s0 == 4) ? int'(dv) : 0;
        b = (s1 == 0) ? int'(av) : (s1 == 1) ? int'(rv) : (s1 == 2) ? 1 : 0;
        c = (sc == 0) ? int'(cv) : (sc == 1) ? 0 : (sc == 2) ? 1 : 1 - int'(cv);
        case (op)
            3'd0: r = c * 16 + a;
            3'd1: r = a + b + c;
            3'd2: r = a * 2 + c;
            3'd3: r = (a % 2) * 16 + c * 8 + a / 2;
            3'd4: r = (a > 9 || c != 0) ? 16 * ((c != 0 || a > 9) ? 1 : 0) + (a + 6) % 16 : c * 16 + a;
            default: r = 0;
        endcase
        return 5'(r);
    endfunction

    assign alu_result = alu_fn(alu_op, alu_in0_sel, alu_in1_sel, alu_cin_sel, alu_regval, alu_acc, alu_data, alu_carry);

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference: each op by its arithmetic meaning; updates the model's acc/carry.
    function automatic exp_t model(input int op, input int d, input int r);
        exp_t e;
        int   t;
        e.we = 0;
        e.wd = 0;
        case (op)
            1:  begin t = m_acc + r + m_c; m_acc = t % 16; m_c = (t > 15) ? 1 : 0; end
            2:  begin t = m_acc - r - m_c; m_acc = (t + 32) % 16; m_c = (t >= 0) ? 1 : 0; end
            3:  m_acc = r;
            4:  begin e.we = 1; e.wd = m_acc; m_acc = r; end
            5:  begin e.we = 1; e.wd = (r + 1) % 16; end
            6:  m_acc = d;
            7:  begin m_acc = 0; m_c = 0; end
            8:  m_c = 0;
            9:  m_c = 1 - m_c;
            10: m_c = 1;
            11: m_acc = 15 - m_acc;
            12: begin t = m_acc * 2 + m_c; m_acc = t % 16; m_c = t / 16; end
            13: begin t = m_c * 16 + m_acc; m_c = m_acc % 2; m_acc = t / 2; end
            14: if (m_acc > 9 || m_c != 0) begin m_c = 1; m_acc = (m_acc + 6) % 16; end
            15: begin t = m_acc + 1; m_acc = t % 16; m_c = (t > 15) ? 1 : 0; end
            default: ;
        endcase
        e.acc = m_acc;
        e.c = m_c;
        e.cyc = cyc + 1;
        return e;
    endfunction

    // Monitor: every done pops one expectation; writeback must never appear without done.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (q.size() == 0) chk("unexpected done", 1, 0);
            else begin
                e = q.pop_front();
                chk("acc", int'(acc), e.acc);
                chk("carry", int'(carry), e.c);
                chk("reg_we", int'(reg_we), e.we);
                if (e.we != 0) chk("reg_wdata", int'(reg_wdata), e.wd);
                chk("done latency", cyc - e.cyc, 2);
            end
        end else if (reg_we) chk("reg_we without done", 1, 0);
    end

    task automatic issue(input int op, input int d, input int r);
        int n = 0;
        @(negedge clk);
        while (!op_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!op_ready) begin
            chk("op_ready timeout", 0, 1);
            return;
        end
        op_valid = 1'b1;
        op_code = 4'(op);
        op_data = 4'(d);
        reg_in = 4'(r);
        q.push_back(model(op, d, r));
        @(negedge clk);
        op_valid = 1'b0;
        op_code = 4'($urandom);
        op_data = 4'($urandom);
        reg_in = 4'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drain", q.size(), 0);
    endtask

    task automatic expect_state(input string name, input int ea, input int ec);
        drain();
        chk({name, " acc"}, int'(acc), ea);
        chk({name, " carry"}, int'(carry), ec);
    endtask

    task automatic back_to_back(input int n);
        int last = -1;
        int op, d, r;
        repeat (n) begin
            @(negedge clk);
            if (op_ready) begin
                if (last >= 0) chk("accept spacing", cyc - last, 3);
                last = cyc;
                op = $urandom_range(0, 15);
                d = $urandom_range(0, 15);
                r = $urandom_range(0, 15);
                op_code = 4'(op);
                op_data = 4'(d);
                reg_in = 4'(r);
                q.push_back(model(op, d, r));
            end else begin
                op_code = 4'($urandom);
                op_data = 4'($urandom);
                reg_in = 4'($urandom);
            end
            op_valid = 1'b1;
        end
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset op_ready", int'(op_ready), 1);
        chk("reset acc", int'(acc), int'(ACC_R));
        chk("reset carry", int'(carry), 0);
        chk("reset done", int'(done), 0);
        chk("reset reg_we", int'(reg_we), 0);
        chk("reset reg_wdata", int'(reg_wdata), 0);
        chk("reset alu_op", int'(alu_op), 0);
        chk("reset in0", int'(alu_in0_sel), 0);
        chk("reset in1", int'(alu_in1_sel), 0);
        chk("reset cin", int'(alu_cin_sel), 0);
        chk("reset regval", int'(alu_regval), 0);
        chk("reset data", int'(alu_data), 0);
        reset_n = 1'b1;
        m_acc = int'(ACC_R);
        m_c = 0;

        issue(6, 9, 0); issue(10, 0, 0); issue(1, 0, 8);
        expect_state("ADD", 2, 1);
        issue(6, 5, 0); issue(8, 0, 0); issue(2, 0, 3);
        expect_state("SUB3", 2, 1);
        issue(6, 5, 0); issue(8, 0, 0); issue(2, 0, 7);
        expect_state("SUB7", 14, 0);
        issue(6, 10, 0); issue(4, 0, 3);
        expect_state("XCH", 3, 0);
        issue(5, 0, 15);
        expect_state("INC", 3, 0);
        issue(6, 9, 0); issue(8, 0, 0); issue(12, 0, 0);
        expect_state("RAL", 2, 1);
        issue(6, 1, 0); issue(10, 0, 0); issue(13, 0, 0);
        expect_state("RAR", 8, 1);
        issue(6, 12, 0); issue(8, 0, 0); issue(14, 0, 0);
        expect_state("DAA", 2, 1);
        issue(6, 15, 0); issue(8, 0, 0); issue(15, 0, 0);
        expect_state("IAC", 0, 1);

        repeat (150) issue($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
        drain();
        back_to_back(60);
        drain();

        // Abort a CMA in EXEC: nothing may be written back or reported.
        issue(6, 7, 0);
        drain();
        @(negedge clk);
        op_valid = 1'b1;
        op_code = 4'd11;
        @(negedge clk);
        op_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("abort acc in reset", int'(acc), int'(ACC_R));
        @(negedge clk);
        reset_n = 1'b1;
        m_acc = int'(ACC_R);
        m_c = 0;
        @(negedge clk);
        chk("abort op_ready", int'(op_ready), 1);
        chk("abort done", int'(done), 0);
        repeat (4) @(negedge clk);
        chk("abort acc", int'(acc), int'(ACC_R));
`ifdef ALU_SEQ_OPCOUNT_EN
        chk("op_count after reset", int'(op_count), 0);
        repeat (300) issue(0, 0, 0);
        drain();
        @(negedge clk);
        chk("op_count saturate", int'(op_count), 255);
`endif
        issue(15, 0, 0);
        drain();
        repeat (3) @(negedge clk);
        chk("queue empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle controller that owns the accumulator and carry registers and sequences the 4-bit ALU for the accumulator/register instruction group.
- Accepts one operation at a time via a valid/ready handshake and drives all ALU selects and operands from registered decode.
- Captures the ALU's 5-bit result and writes back accumulator, carry and/or the register-file operand.
- Sits between the instruction decoder and the ALU; the register file is external.

Parameters:
- ACC_RESET, 4'h0, accumulator value after reset.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- op_valid  in  1  operation request.
- op_ready  out  1  sequencer can accept; high only in IDLE.
- op_code  in  4  operation, encoding listed under Behaviour.
- op_data  in  4  immediate for LDM.
- reg_in  in  4  register-file operand, sampled at accept.
- alu_op  out  3  to ALU, ALU_OP_* encoding.
- alu_in0_sel  out  3  to ALU, ALU_IN0_* encoding.
- alu_in1_sel  out  2  to ALU, ALU_IN1_* encoding.
- alu_cin_sel  out  2  to ALU, ALU_CIN_* encoding.
- alu_regval  out  4  latched reg_in.
- alu_acc  out  4  current accumulator.
- alu_data  out  4  latched op_data for LDM, else 0.
- alu_carry  out  1  current carry.
- alu_result  in  5  ALU result.
- reg_we  out  1  register-file write strobe, one cycle.
- reg_wdata  out  4  register-file write data.
- acc  out  4  accumulator.
- carry  out  1  carry flag.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Clock and reset: one clock, `clock`. Reset `reset_n` is asynchronous and active-low.
- Reset values:
  - State IDLE, acc=ACC_RESET, carry=0, done=0, reg_we=0, reg_wdata=0.
  - Latched op, data and reg all 0.
  - ALU controls at idle default: PASS, IN0_ACC, IN1_ACC, CIN_CARRY.
- Reset mid-operation aborts the operation immediately: no writeback, no done, and op_ready is high in the first cycle after release.
- FSM: IDLE -> EXEC -> WB -> IDLE.
  - IDLE: op_ready=1. op_valid&op_ready latches op_code, op_data and reg_in, then goes to EXEC. op_valid while not ready is ignored, not queued.
  - EXEC: ALU controls are driven from registered decode (glitch-free, no combinational path from op_code). alu_result is registered at the end of EXEC.
  - WB:
    - if acc_we, acc <= result[3:0]; if carry_we, carry <= result[4].
    - reg_we=1 where the op writes the register file; done=1.
    - Return to IDLE; ALU controls revert to the idle default.
- Latency: done is high 2 cycles after the accept edge. Throughput is one op per 3 cycles. acc/carry are visible in the cycle after WB.
- Ops, listed as code: name, ALU op/in0/in1/cin, writes.
  - 0: NOP, idle default, none; done still pulses.
  - 1: ADD, ADD/ACC/REG/CARRY, acc+carry.
  - 2: SUB, ADD/ACC/ONE_INV... not used; uses ADD/REG_INV/ACC/CARRY_INV, acc+carry.
  - 3: LD, PASS/REG/-/CARRY, acc.
  - 4: XCH, PASS/REG/-/CARRY, acc; reg_we with reg_wdata = pre-op acc.
  - 5: INC, ADD/REG/ONE/ZERO; reg_we with reg_wdata = result[3:0]; carry unaffected.
  - 6: LDM, PASS/DATA/-/CARRY, acc.
  - 7: CLB, PASS/DATA(0)/-/ZERO, acc+carry.
  - 8: CLC, PASS/ACC/-/ZERO, carry.
  - 9: CMC, PASS/ACC/-/CARRY_INV, carry.
  - 10: STC, PASS/ACC/-/ONE, carry.
  - 11: CMA, PASS/ACC_INV/-/CARRY, acc.
  - 12: RAL, ROL/ACC/-/CARRY, acc+carry.
  - 13: RAR, ROR/ACC/-/CARRY, acc+carry.
  - 14: DAA, DEC_A/ACC/-/CARRY, acc+carry; carry ends as old carry OR acc>9.
  - 15: IAC, ADD/ACC/ONE/ZERO, acc+carry.
- Unused in1 is driven IN1_ACC. X is never driven on any output.
- Wrap-around is 4-bit modulo; result[4] is the carry out, e.g. IAC of F gives 0 with carry=1.

Optional Feature:
- Macro ALU_SEQ_OPCOUNT_EN.
  - Defined: adds output op_count [7:0], which increments on every done pulse, saturates at 8'hFF, and resets to 0.
  - Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then ADD with acc=9, carry=1, reg_in=8 -> done 2 cycles after accept; acc=2, carry=1, reg_we=0.
- SUB with acc=5, carry=0 (no borrow), reg_in=3 -> acc=2, carry=1. Same with reg_in=7 -> acc=E, carry=0.
- XCH with acc=A, reg_in=3 -> reg_we pulse with reg_wdata=A in the done cycle; acc=3. INC with reg_in=F -> reg_wdata=0, carry unchanged.
- RAL with acc=9, carry=0 -> acc=2, carry=1. RAR with acc=1, carry=1 -> acc=8, carry=1. DAA with acc=C, carry=0 -> acc=2, carry=1.
- Back-to-back op_valid held high -> accepts every 3rd cycle and op_ready=0 in EXEC/WB. Assert reset_n low during EXEC of CMA -> acc=ACC_RESET, no done, op_ready=1 after release.
- With ALU_SEQ_OPCOUNT_EN, run 300 NOPs -> op_count=FF; without it, the build contains no op_count port.
